// File: rtl/popcount_arb_pkg.sv
// Shared types and default parameters for the popcount arbiter slice.
package popcount_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    DRAIN  = 3'd2,
    RESULT = 3'd3,
    CLEAR  = 3'd4
  } arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DRAIN_MIN      = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first asserted req at or after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        gnt        = '0;
        gnt[k]     = 1'b1;
        gnt_idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin job scheduler in front of a shared popcount datapath.
// Optional drain watchdog and RES_ERR port: define POPCOUNT_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | pick next requester round-robin
// STREAM | forward granted requester's beats to popcount
// DRAIN  | wait for popcount to settle after the LAST beat
// RESULT | hold result until consumer accepts
// CLEAR  | pulse PC_COUNT_RST for one cycle
module popcount_arbiter
  import popcount_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DRAIN_MIN      = DEF_DRAIN_MIN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  input  logic [NUM_REQ-1:0][31:0]   REQ_DATA,
  input  logic [NUM_REQ-1:0]         REQ_LAST,
  output logic [NUM_REQ-1:0]         REQ_READY,
  output logic [31:0]                PC_WRITE_DATA,
  output logic                       PC_WRITE_VALID,
  input  logic [31:0]                PC_COUNT,
  input  logic                       PC_COUNT_BUSY,
  output logic                       PC_COUNT_RST,
  output logic                       RES_VALID,
  input  logic                       RES_READY,
  output logic [$clog2(NUM_REQ)-1:0] RES_ID,
  output logic [31:0]                RES_COUNT
`ifdef POPCOUNT_ARB_TIMEOUT_EN
  ,
  output logic                       RES_ERR
`endif
);

  localparam int IW        = $clog2(NUM_REQ);
  localparam int CNT_MAX_I = (DRAIN_MIN > TIMEOUT_CYCLES) ? DRAIN_MIN : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(CNT_MAX_I + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CNT_MAX_I);
  localparam logic [CW-1:0] DRAIN_THR = CW'(DRAIN_MIN);
`ifdef POPCOUNT_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TO_THR    = CW'(TIMEOUT_CYCLES);
`endif

  arb_state_t          state;
  logic [IW-1:0]       g;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       rr_next;
  logic [NUM_REQ-1:0]  ready_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;
  logic [CW-1:0]       drain_cnt;
  logic [CW-1:0]       cnt_inc;
  logic                beat;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (REQ_VALID),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign beat           = (state == STREAM) && REQ_VALID[g];
  assign REQ_READY      = ready_q;
  assign PC_WRITE_VALID = beat;
  assign PC_WRITE_DATA  = REQ_DATA[g];
  assign rr_next        = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  // Threshold checks look at the post-increment value so a job needs only DRAIN_MIN drain cycles.
  assign cnt_inc        = (drain_cnt == CNT_MAX) ? drain_cnt : drain_cnt + 1'b1;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= IDLE;
      g            <= '0;
      rr_ptr       <= '0;
      ready_q      <= '0;
      drain_cnt    <= '0;
      PC_COUNT_RST <= 1'b0;
      RES_VALID    <= 1'b0;
      RES_ID       <= '0;
      RES_COUNT    <= '0;
`ifdef POPCOUNT_ARB_TIMEOUT_EN
      RES_ERR      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|REQ_VALID) begin
            g       <= gnt_idx;
            ready_q <= gnt;
            rr_ptr  <= rr_next;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (beat && REQ_LAST[g]) begin
            ready_q   <= '0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= cnt_inc;
          if ((cnt_inc >= DRAIN_THR) && !PC_COUNT_BUSY) begin
            RES_COUNT <= PC_COUNT;
            RES_ID    <= g;
            RES_VALID <= 1'b1;
            state     <= RESULT;
          end
`ifdef POPCOUNT_ARB_TIMEOUT_EN
          else if ((cnt_inc >= TO_THR) && PC_COUNT_BUSY) begin
            RES_COUNT <= PC_COUNT;
            RES_ID    <= g;
            RES_ERR   <= 1'b1;
            RES_VALID <= 1'b1;
            state     <= RESULT;
          end
`endif
        end
        RESULT: begin
          if (RES_READY) begin
            RES_VALID    <= 1'b0;
            PC_COUNT_RST <= 1'b1;
`ifdef POPCOUNT_ARB_TIMEOUT_EN
            RES_ERR      <= 1'b0;
`endif
            state        <= CLEAR;
          end
        end
        CLEAR: begin
          PC_COUNT_RST <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/popcount_arbiter.md
# popcount_arbiter

Round-robin scheduler that shares one `popcount` datapath between `NUM_REQ` requesters. Each granted requester streams a burst of 32-bit words into the datapath. The arbiter waits for counting to finish, returns the count tagged with the requester ID, and clears the datapath before granting the next job. It sits between the MMIO/stream front ends and the `popcount` instance, and drives that instance's `WRITE_*` and `COUNT_RST` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DRAIN_MIN`, 2: cycles `PC_COUNT_BUSY` is ignored after the last beat, covering busy-rise latency.
- `TIMEOUT_CYCLES`, 1024: drain watchdog limit; used only with `POPCOUNT_ARB_TIMEOUT_EN`.

- `ACLK` input 1: clock; all state changes on the rising edge.
- `ARESET` input 1: asynchronous, active-high reset.
- `REQ_VALID` input `NUM_REQ`: per-requester word valid.
- `REQ_DATA` input `NUM_REQ`x32: per-requester word.
- `REQ_LAST` input `NUM_REQ`: marks the final word of a burst.
- `REQ_READY` output `NUM_REQ`: per-requester accept.
- `PC_WRITE_DATA` output 32: to popcount `WRITE_DATA`.
- `PC_WRITE_VALID` output 1: to popcount `WRITE_VALID`.
- `PC_COUNT` input 32: from popcount `COUNT`.
- `PC_COUNT_BUSY` input 1: from popcount `COUNT_BUSY`.
- `PC_COUNT_RST` output 1: to popcount `COUNT_RST`.
- `RES_VALID` output 1: result available.
- `RES_READY` input 1: result consumer accept.
- `RES_ID` output `$clog2(NUM_REQ)`: requester that owns the result.
- `RES_COUNT` output 32: captured count.
- `RES_ERR` output 1: watchdog fired; present only with `POPCOUNT_ARB_TIMEOUT_EN`.

## Operation
- States: `IDLE`, `STREAM`, `DRAIN`, `RESULT`, `CLEAR`.
- `IDLE`:
  - If any `REQ_VALID` is high, grant the first asserted index at or after the round-robin pointer `rr_ptr`.
  - Latch the grant `g`, set `rr_ptr` to `g+1` (mod `NUM_REQ`), then go to `STREAM`.
  - If no `REQ_VALID` is high, remain in `IDLE`.
- `STREAM`:
  - `REQ_READY[g]` is 1; every other `REQ_READY` bit is 0.
  - `PC_WRITE_VALID = REQ_VALID[g]` and `PC_WRITE_DATA = REQ_DATA[g]`, both combinational.
  - A beat is transferred when `REQ_VALID[g]` is high.
  - A beat with `REQ_LAST[g]` high goes to `DRAIN` and clears the drain counter.
  - If `REQ_VALID[g]` drops mid-burst, the grant is held and no beats are transferred (stall).
- `DRAIN`:
  - The counter increments every cycle.
  - Once the counter reaches `DRAIN_MIN` and `PC_COUNT_BUSY` is 0, capture `RES_COUNT <= PC_COUNT` and `RES_ID <= g`, then go to `RESULT`.
- `RESULT`: `RES_VALID` is 1 and `RES_COUNT`/`RES_ID` stay stable until `RES_READY` is sampled high, then go to `CLEAR`.
- `CLEAR`: `PC_COUNT_RST` is 1 for exactly one cycle, then go to `IDLE`.
- Requester VALIDs outside the grant are ignored. Their data is not consumed and they are not starved: round-robin guarantees service within `NUM_REQ` jobs.
- Widths:
  - The drain counter is wide enough for `max(DRAIN_MIN, TIMEOUT_CYCLES)` and saturates.
  - `rr_ptr` wraps from `NUM_REQ-1` to 0.

## Timing
- Reset values, applied asynchronously while `ARESET` is high:
  - State `IDLE`, `rr_ptr` = 0.
  - All `REQ_READY` bits, `PC_WRITE_VALID`, `PC_COUNT_RST`, `RES_VALID` and `RES_ERR` are 0.
  - `RES_ID` = 0 and `RES_COUNT` = 0.
- Reset mid-burst drops the burst and produces no result. The popcount instance is reset by its own reset.
- The grant decision takes 1 cycle (`IDLE`→`STREAM`). The first beat is accepted no earlier than the cycle after the requester's `REQ_VALID` is first seen in `IDLE`.
- A single-word burst with `LAST` on the first beat is legal and goes straight to `DRAIN`.
- Minimum job latency from the `LAST` beat to `RES_VALID` is `DRAIN_MIN`+1 cycles.
- `PC_COUNT_RST` asserts the cycle after the `RES_VALID`/`RES_READY` handshake.
- The next grant cannot occur before the cycle after `CLEAR`. Back-to-back jobs therefore have a 2-cycle gap (`CLEAR`, `IDLE`) between a result handshake and the next `STREAM`.
- `RES_READY` high in the same cycle `RES_VALID` first rises completes the handshake in that cycle.

## Configuration
- `POPCOUNT_ARB_TIMEOUT_EN` defined:
  - In `DRAIN`, once the counter reaches `TIMEOUT_CYCLES` with `PC_COUNT_BUSY` still 1, capture `RES_COUNT <= PC_COUNT`, set `RES_ERR` = 1 and go to `RESULT`.
  - `RES_ERR` is valid alongside `RES_VALID` and clears in `CLEAR`.
- `POPCOUNT_ARB_TIMEOUT_EN` undefined: the `RES_ERR` port is absent and `DRAIN` waits indefinitely for `PC_COUNT_BUSY` to fall.

## Structure
- Package `popcount_arb_pkg` holds:
  - The state enum `arb_state_t`.
  - The default localparams for `NUM_REQ`, `DRAIN_MIN` and `TIMEOUT_CYCLES`.
- Sub-module `rr_arbiter`: a combinational round-robin priority select taking `req` and `ptr` and producing one-hot `gnt` and index `gnt_idx`, instantiated once.
- All sequencing logic lives in `popcount_arbiter`.

## Test plan
- Single job: requester 0 sends 0xFFFFFFFF then 0x0000000F (LAST) → `RES_VALID` with `RES_ID`=0 and `RES_COUNT`=36, followed by a one-cycle `PC_COUNT_RST` pulse.
- Round-robin: all 4 requesters hold `VALID` with 1-word bursts of 0x1, 0x3, 0x7, 0xF → results in `RES_ID` order 0,1,2,3 with counts 1,2,3,4; a second round starts again at 0.
- Stall: requester 2 drops `VALID` for 5 cycles mid-burst while requester 1 is valid → grant stays on 2, requester 1 sees `REQ_READY`=0, and the result is correct for the full burst.
- Result backpressure: `RES_READY` is held low for 10 cycles → `RES_VALID`, `RES_COUNT` and `RES_ID` stay stable, `PC_COUNT_RST` stays 0, and no new grant is issued.
- Reset mid-`STREAM`: `ARESET` is pulsed after 2 beats → all outputs are 0 immediately, state is `IDLE`, `rr_ptr`=0, and the next job is granted to the lowest valid index.
- With `POPCOUNT_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: the model holds `PC_COUNT_BUSY` at 1 forever → `RES_VALID` with `RES_ERR`=1 appears 17 cycles after `LAST`, and `RES_ERR` clears after `CLEAR`.
